// File: rtl/fn_sw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fn_sw_pkg                                              |
// | Description : Shared encodings for the logic-unit issue/collect     |
// |               block: function selects and command field positions.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package fn_sw_pkg;

   // Packed command layout: {sel[1:0], b, a}
   localparam int CMD_W      = 4;
   localparam int CMD_A      = 0;
   localparam int CMD_B      = 1;
   localparam int CMD_SEL_LO = 2;
   localparam int CMD_SEL_HI = 3;

   // Function select seen by the downstream logic unit
   typedef enum logic [1:0] {
      FN_AND  = 2'b00,
      FN_OR   = 2'b01,
      FN_XOR  = 2'b10,
      FN_XNOR = 2'b11
   } fn_sel_e;

endpackage
`default_nettype wire

// File: rtl/fn_sw_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fn_sw_fifo                                             |
// | Description : Small synchronous FIFO. Extra pointer MSB separates    |
// |               full from empty; reads are combinational from the     |
// |               head entry, so a write is visible the following cycle.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module fn_sw_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = ({~wptr_q[AW], wptr_q[AW-1:0]} == rptr_q);
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   // Pointer advance; wrap-around falls out of the natural overflow
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (w_push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (w_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
   end

   // Pointer registers; reset empties the FIFO regardless of contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage is not reset: stale entries are unreachable once pointers clear
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fn_sw_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fn_sw_issue                                            |
// | Description : Queues {sel,b,a} commands, issues one per cycle to an  |
// |               external 1-bit logic unit, samples its result a cycle |
// |               later and packs results LSB-first into output words.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module fn_sw_issue
   import fn_sw_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int RES_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CMD_W-1:0] in_cmd,
   output logic             a,
   output logic             b,
   output logic [1:0]       sel,
   input  logic             y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data
);

   localparam int              CNT_W    = $clog2(RES_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_W - 1);

   logic [CMD_W-1:0] w_fifo_rdata;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_issue;
   logic             w_last;
   logic [RES_W-1:0] w_pack_y;

   logic             a_q, a_d;
   logic             b_q, b_d;
   logic [1:0]       sel_q, sel_d;
   logic             op_vld_q, op_vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RES_W-1:0] pack_q, pack_d;
   logic             res_valid_q, res_valid_d;
   logic [RES_W-1:0] res_data_q, res_data_d;

   fn_sw_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid),
      .wdata_i (in_cmd),
      .pop_i   (w_issue),
      .rdata_o (w_fifo_rdata),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

   // Readiness depends on occupancy only; a same-cycle pop does not free a slot
   assign in_ready = !w_fifo_full;

   // The in-flight op is the last bit of its word
   assign w_last = op_vld_q && (cnt_q == CNT_LAST);

   // Hold issue while a word waits for the consumer or is about to be produced
   assign w_issue = !w_fifo_empty && !res_valid_q && !w_last;

   // Issue stage: load operands from the FIFO head, otherwise hold them
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      op_vld_d = 1'b0;
      if (w_issue) begin
         a_d      = w_fifo_rdata[CMD_A];
         b_d      = w_fifo_rdata[CMD_B];
         sel_d    = w_fifo_rdata[CMD_SEL_HI:CMD_SEL_LO];
         op_vld_d = 1'b1;
      end
   end

   // Capture/pack stage: drop y into bit cnt and publish full words
   always_comb begin
      cnt_d          = cnt_q;
      pack_d         = pack_q;
      res_valid_d    = res_valid_q;
      res_data_d     = res_data_q;
      w_pack_y       = pack_q;
      w_pack_y[cnt_q] = y;
      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
      if (op_vld_q) begin
         if (cnt_q == CNT_LAST) begin
            res_data_d  = w_pack_y;
            res_valid_d = 1'b1;
            cnt_d       = '0;
            pack_d      = '0;
         end else begin
            pack_d = w_pack_y;
            cnt_d  = cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset discards in-flight op and any partial word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         sel_q       <= 2'b00;
         op_vld_q    <= 1'b0;
         cnt_q       <= '0;
         pack_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         op_vld_q    <= op_vld_d;
         cnt_q       <= cnt_d;
         pack_q      <= pack_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign sel       = sel_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fn_sw_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fn_sw_issue                                         |
// | Description : Self-checking bench for fn_sw_issue with the 4-function|
// |               logic unit closed around it, a queue-based reference  |
// |               model and directed scenarios with literal results.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_fn_sw_issue;

   localparam int DEPTH = 4;
   localparam int RES_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_cmd = 4'h0;
   logic             a;
   logic             b;
   logic [1:0]       sel;
   logic             y;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [RES_W-1:0] res_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Logic unit: AND/OR/XOR/XNOR
   function automatic logic lu_f(input logic [1:0] s, input logic aa, input logic bb);
      case (s)
         2'b00:   lu_f = aa & bb;
         2'b01:   lu_f = aa | bb;
         2'b10:   lu_f = aa ^ bb;
         default: lu_f = ~(aa ^ bb);
      endcase
   endfunction

   assign y = lu_f(sel, a, b);

   fn_sw_issue #(
      .DEPTH (DEPTH),
      .RES_W (RES_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cmd    (in_cmd),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .y         (y),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [3:0]       mq[$];
   bit               mbits[$];
   bit               m_inflight = 0;
   logic [3:0]       m_cmd = 4'h0;
   bit               m_rv = 0;
   logic [RES_W-1:0] m_rd = '0;
   logic [3:0]       m_abs = 4'h0;   // {sel,b,a} presented to the unit

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            mbits.delete();
            m_inflight = 0;
            m_cmd      = 4'h0;
            m_rv       = 0;
            m_rd       = '0;
            m_abs      = 4'h0;
         end else begin
            bit do_push;
            bit do_issue;
            do_push  = in_valid && (mq.size() < DEPTH);
            do_issue = (mq.size() != 0) && !m_rv &&
                       !(m_inflight && (mbits.size() == RES_W - 1));
            if (m_rv && res_ready) m_rv = 0;
            if (m_inflight) begin
               mbits.push_back(lu_f(m_cmd[3:2], m_cmd[0], m_cmd[1]));
               if (mbits.size() == RES_W) begin
                  for (int i = 0; i < RES_W; i++) m_rd[i] = mbits[i];
                  m_rv = 1;
                  mbits.delete();
               end
            end
            if (do_issue) begin
               m_cmd      = mq.pop_front();
               m_abs      = m_cmd;
               m_inflight = 1;
            end else begin
               m_inflight = 0;
            end
            if (do_push) mq.push_back(in_cmd);
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      @(negedge clk);
      forever begin
         @(negedge clk);
         chk("cmp_in_ready",  in_ready,  (mq.size() < DEPTH) ? 1 : 0);
         chk("cmp_abs",       {sel, b, a}, m_abs);
         chk("cmp_res_valid", res_valid, m_rv);
         chk("cmp_res_data",  res_data,  m_rd);
      end
   end

   // Accepted output words
   logic [RES_W-1:0] got[$];
   always @(posedge clk) begin
      if (!rst && res_valid && res_ready) got.push_back(res_data);
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [3:0] c, output int acc);
      bit done;
      done = 0;
      acc  = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_cmd   = c;
      for (int k = 0; k < 200 && !done; k++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            acc  = cyc;
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) bound_fail("push_accept");
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm, output int at);
      bit done;
      done = 0;
      at   = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (res_valid) begin
            at   = cyc;
            done = 1;
         end
      end
      if (!done) bound_fail(nm);
   endtask

   task automatic wait_full(input string nm);
      bit done;
      done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (!in_ready) done = 1;
      end
      if (!done) bound_fail(nm);
   endtask

   task automatic wait_words(input string nm, input int n);
      bit done;
      done = 0;
      for (int k = 0; k < 120 && !done; k++) begin
         @(negedge clk);
         if (got.size() >= n) done = 1;
      end
      if (!done) bound_fail(nm);
   endtask

   // ---------------- directed scenarios ----------------
   logic [3:0] bp_cmds [12] = '{4'b0011, 4'b0101, 4'b1001, 4'b1100,
                                4'b0001, 4'b0110, 4'b1011, 4'b1101,
                                4'b1111, 4'b1010, 4'b0100, 4'b0000};

   initial begin
      int t0;
      int tx;
      int at;

      // Reset with in_valid asserted
      rst      = 1'b1;
      in_valid = 1'b1;
      in_cmd   = 4'b1111;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_abs",       {sel, b, a}, 4'b0000);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data",  res_data, 4'b0000);
      in_valid = 1'b0;
      rst      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_no_push_abs",   {sel, b, a}, 4'b0000);
      chk("rst_no_push_valid", res_valid, 0);

      // Mixed word: every function yields 1
      push(4'b0011, t0);
      push(4'b0101, tx);
      push(4'b1001, tx);
      push(4'b1100, tx);
      idle();
      wait_valid("mixed_wait", at);
      chk("mixed_latency", at - t0, 5);
      chk("mixed_data", res_data, 4'b1111);
      @(negedge clk);
      chk("mixed_one_cycle", res_valid, 0);

      // Bit order: results 0,1,0,0 LSB-first
      push(4'b0001, tx);
      push(4'b0110, tx);
      push(4'b1011, tx);
      push(4'b1101, tx);
      idle();
      wait_valid("order_wait", at);
      chk("order_data", res_data, 4'b0010);
      repeat (3) @(negedge clk);

      // Backpressure: 12 commands with the consumer stalled
      got.delete();
      res_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++) push(bp_cmds[i], tx);
            idle();
         end
         begin
            wait_full("bp_fill");
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_word_pending", res_valid, 1);
            chk("bp_hold_abs", {sel, b, a}, 4'b1100);
            repeat (8) @(negedge clk);
            chk("bp_hold_abs_late", {sel, b, a}, 4'b1100);
            chk("bp_still_full", in_ready, 0);
            chk("bp_data_held", res_data, 4'b1111);
            res_ready = 1'b1;
         end
      join
      wait_words("bp_words", 3);
      chk("bp_word_count", got.size(), 3);
      if (got.size() >= 3) begin
         chk("bp_word0", got[0], 4'b1111);
         chk("bp_word1", got[1], 4'b0010);
         chk("bp_word2", got[2], 4'b0011);
      end
      repeat (3) @(negedge clk);

      // Full boundary: in_valid on the cycle issue resumes
      got.delete();
      res_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(bp_cmds[i], tx);
      idle();
      wait_full("fb_fill");
      chk("fb_full", in_ready, 0);
      chk("fb_pending", res_valid, 1);
      res_ready = 1'b1;
      @(negedge clk);
      chk("fb_handshake_done", res_valid, 0);
      chk("fb_still_full", in_ready, 0);
      in_valid = 1'b1;
      in_cmd   = bp_cmds[8];
      @(negedge clk);
      chk("fb_no_push_on_resume", in_ready, 1);
      @(posedge clk);
      #1;
      for (int i = 9; i < 12; i++) push(bp_cmds[i], tx);
      idle();
      wait_words("fb_words", 3);
      chk("fb_word_count", got.size(), 3);
      if (got.size() >= 3) begin
         chk("fb_word0", got[0], 4'b1111);
         chk("fb_word1", got[1], 4'b0010);
         chk("fb_word2", got[2], 4'b0011);
      end
      repeat (3) @(negedge clk);

      // Mid-operation asynchronous reset with two results packed
      got.delete();
      res_ready = 1'b1;
      push(4'b0011, tx);
      push(4'b0101, tx);
      push(4'b1001, tx);
      push(4'b1100, tx);
      #2;
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("mrst_abs",       {sel, b, a}, 4'b0000);
      chk("mrst_res_valid", res_valid, 0);
      chk("mrst_res_data",  res_data, 4'b0000);
      chk("mrst_in_ready",  in_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push(4'b0000, tx);
      push(4'b0111, tx);
      push(4'b1011, tx);
      push(4'b1100, tx);
      idle();
      wait_words("mrst_words", 1);
      if (got.size() >= 1) chk("mrst_word", got[0], 4'b1010);
      repeat (10) @(negedge clk);
      chk("mrst_word_count", got.size(), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time bound expired, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1);
   end

endmodule
`default_nettype wire
